// File: rtl/uart_rx2tx_bridge.sv
// uart_rx2tx_bridge: buffers words captured on the falling edge of rx_done and
// replays them to the UART transmitter as tx_start pulses aligned to txclk.
// Optional feature macro: RX2TX_OVERFLOW_FLAG_EN (sticky overflow flag).
// Without the macro, overflow is tied low; dropping behaviour is unchanged.
module uart_rx2tx_bridge #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_done,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       txclk,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    START = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] rx_sync_r;
  logic [SYNC_STAGES-1:0] tx_sync_r;
  logic                   rx_hist_r;
  logic                   tx_hist_r;
  logic                   neg_rx_s;
  logic                   neg_tx_s;
  logic                   pos_tx_s;

  state_t                 state_r;
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [DATA_W-1:0]      mem_r [DEPTH];
  logic                   full_s;
  logic                   pop_s;
  logic                   push_s;

  // Synchronise rx_done and txclk into clk and keep one history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_r <= {SYNC_STAGES{1'b0}};
      tx_sync_r <= {SYNC_STAGES{1'b0}};
      rx_hist_r <= 1'b0;
      tx_hist_r <= 1'b0;
    end else begin
      rx_sync_r <= {rx_sync_r[SYNC_STAGES-2:0], rx_done};
      tx_sync_r <= {tx_sync_r[SYNC_STAGES-2:0], txclk};
      rx_hist_r <= rx_sync_r[SYNC_STAGES-1];
      tx_hist_r <= tx_sync_r[SYNC_STAGES-1];
    end
  end

  assign neg_rx_s = rx_hist_r & ~rx_sync_r[SYNC_STAGES-1];
  assign neg_tx_s = tx_hist_r & ~tx_sync_r[SYNC_STAGES-1];
  assign pos_tx_s = ~tx_hist_r & tx_sync_r[SYNC_STAGES-1];

  // A word leaves the FIFO only when the start pulse ends; a push into a full
  // FIFO is still accepted when that same cycle frees an entry.
  assign full_s = (fifo_count == CNT_W'(DEPTH));
  assign pop_s  = (state_r == START) && pos_tx_s;
  assign push_s = neg_rx_s && (!full_s || pop_s);

  // Start-pulse sequencer: wait for data and an idle transmitter, then frame tx_start on txclk edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      tx_start <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if ((fifo_count != CNT_W'(0)) && !tx_busy) begin
            state_r <= ARM;
          end else begin
            state_r <= IDLE;
          end
          tx_start <= 1'b0;
        end
        ARM: begin
          // a txclk rising edge seen here is deliberately ignored
          if (neg_tx_s) begin
            state_r  <= START;
            tx_start <= 1'b1;
          end else begin
            state_r  <= ARM;
            tx_start <= 1'b0;
          end
        end
        START: begin
          if (pos_tx_s) begin
            state_r  <= IDLE;
            tx_start <= 1'b0;
          end else begin
            state_r  <= START;
            tx_start <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          tx_start <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= PTR_W'(0);
      rd_ptr_r   <= PTR_W'(0);
      fifo_count <= CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

  // Head of the FIFO, forced to zero while empty so stale storage never leaks out.
  assign tx_data = (fifo_count != CNT_W'(0)) ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};

`ifdef RX2TX_OVERFLOW_FLAG_EN
  logic drop_s;
  logic overflow_r;

  assign drop_s = neg_rx_s && full_s && !pop_s;

  // Sticky flag set by the first dropped word, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow = overflow_r;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx2tx_bridge.sv
// Scoreboard bench for uart_rx2tx_bridge: a DEPTH=16 instance for the main
// scenarios and a DEPTH=4 instance for pointer wrap-around.
module tb_uart_rx2tx_bridge;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       rx_done  = 1'b0;
  logic       rx_done4 = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       txclk    = 1'b0;
  logic       tx_busy  = 1'b0;

  logic       tx_start,  tx_start4;
  logic [7:0] tx_data,   tx_data4;
  logic [4:0] fifo_count;
  logic [2:0] fifo_count4;
  logic       overflow,  overflow4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tx_fall_cyc = 0;
  int tx_rise_cyc = 0;
  int start_cnt   = 0;
  logic       prev_start  = 1'b0;
  logic       prev_start4 = 1'b0;
  logic [7:0] held_data   = 8'h00;
  logic [7:0] sb  [$];
  logic [7:0] sb4 [$];

`ifdef RX2TX_OVERFLOW_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  uart_rx2tx_bridge #(.DATA_W(8), .DEPTH(16), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .txclk(txclk), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  uart_rx2tx_bridge #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .reset(reset), .rx_done(rx_done4), .rx_data(rx_data),
    .txclk(txclk), .tx_busy(tx_busy), .tx_start(tx_start4), .tx_data(tx_data4),
    .fifo_count(fifo_count4), .overflow(overflow4)
  );

  // clk period 10, txclk = clk/16; txclk edges land on clk falling edges
  always #5  clk   = ~clk;
  always #80 txclk = ~txclk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge txclk) tx_fall_cyc = cyc;
  always @(posedge txclk) tx_rise_cyc = cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // output monitor: start/stop latency, data order against scoreboard, data stability
  always @(negedge clk) begin
    logic [7:0] exp;
    if (reset) begin
      prev_start  = 1'b0;
      prev_start4 = 1'b0;
    end else begin
      if (tx_start && !prev_start) begin
        start_cnt++;
        check_eq("start_latency", cyc - tx_fall_cyc, 3);
        check_eq("start_with_data_queued", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check_eq("tx_data_order", tx_data, exp);
        end
        held_data = tx_data;
      end else if (tx_start) begin
        check_eq("tx_data_stable", tx_data, held_data);
      end
      if (!tx_start && prev_start) begin
        check_eq("stop_latency", cyc - tx_rise_cyc, 3);
      end
      prev_start = tx_start;

      if (tx_start4 && !prev_start4) begin
        check_eq("d4_start_with_data_queued", sb4.size() != 0, 1);
        if (sb4.size() != 0) begin
          exp = sb4.pop_front();
          check_eq("d4_tx_data_order", tx_data4, exp);
        end
      end
      prev_start4 = tx_start4;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    sb4.delete();
  endtask

  task automatic send_word(input bit to4, input logic [7:0] d, input bit accept, input bit chk_lat);
    logic [4:0] old;
    @(negedge clk);
    rx_data = d;
    if (to4) rx_done4 = 1'b1; else rx_done = 1'b1;
    repeat (4) @(negedge clk);
    if (to4) rx_done4 = 1'b0; else rx_done = 1'b0;
    if (accept) begin
      if (to4) sb4.push_back(d); else sb.push_back(d);
    end
    if (chk_lat) begin
      old = fifo_count;
      @(posedge clk);
      @(posedge clk);
      #1 check_eq("push_not_before_3rd_edge", fifo_count, old);
      @(posedge clk);
      #1 check_eq("push_at_3rd_edge", fifo_count, old + 5'd1);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_start();
    int i;
    for (i = 0; i < 400 && !tx_start; i++) @(negedge clk);
    check_eq("tx_start_seen", tx_start, 1'b1);
  endtask

  task automatic wait_stop();
    int i;
    for (i = 0; i < 400 && tx_start; i++) @(negedge clk);
    check_eq("tx_start_dropped", tx_start, 1'b0);
  endtask

  task automatic wait_drain(input bit to4);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (to4) done = (sb4.size() == 0) && !tx_start4 && (fifo_count4 == 3'd0);
      else     done = (sb.size() == 0) && !tx_start && (fifo_count == 5'd0);
    end
    check_eq(to4 ? "d4_drain_complete" : "drain_complete", done, 1'b1);
  endtask

  initial begin
    int n0;
    // reset state
    #1;
    check_eq("reset_tx_start", tx_start, 1'b0);
    check_eq("reset_tx_data", tx_data, 8'h00);
    check_eq("reset_fifo_count", fifo_count, 5'd0);
    check_eq("reset_overflow", overflow, 1'b0);
    do_reset();

    // single word with push-latency check
    send_word(1'b0, 8'hA5, 1'b1, 1'b1);
    wait_start();
    check_eq("single_tx_data", tx_data, 8'hA5);
    wait_stop();
    check_eq("single_count_after_pop", fifo_count, 5'd0);
    check_eq("single_tx_data_empty", tx_data, 8'h00);

    // burst held off by tx_busy
    tx_busy = 1'b1;
    n0 = start_cnt;
    for (int i = 1; i <= 5; i++) send_word(1'b0, 8'(i), 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check_eq("burst_count", fifo_count, 5'd5);
    check_eq("burst_no_start_while_busy", start_cnt, n0);
    tx_busy = 1'b0;
    wait_drain(1'b0);
    check_eq("burst_start_count", start_cnt, n0 + 5);

    // overflow: 17 words into 16 entries
    tx_busy = 1'b1;
    n0 = start_cnt;
    for (int i = 0; i < 17; i++) send_word(1'b0, 8'(i), i < 16, 1'b0);
    check_eq("ovf_count_full", fifo_count, 5'd16);
    check_eq("ovf_flag", overflow, OVF_EXP);
    tx_busy = 1'b0;
    wait_drain(1'b0);
    repeat (64) @(negedge clk);
    check_eq("ovf_sent_16_only", start_cnt, n0 + 16);
    check_eq("ovf_flag_sticky", overflow, OVF_EXP);

    // full FIFO with a push landing on the pop cycle
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) send_word(1'b0, 8'h40 + 8'(i), 1'b1, 1'b0);
    check_eq("full_count", fifo_count, 5'd16);
    @(negedge clk);
    rx_data = 8'h50;
    rx_done = 1'b1;
    tx_busy = 1'b0;
    wait_start();
    @(posedge txclk);
    rx_done = 1'b0;
    sb.push_back(8'h50);
    wait_stop();
    check_eq("full_pushpop_count", fifo_count, 5'd16);
    check_eq("full_pushpop_no_overflow", overflow, 1'b0);
    wait_drain(1'b0);
    check_eq("full_pushpop_overflow_end", overflow, 1'b0);

    // wrap-around on the DEPTH=4 instance
    for (int i = 0; i < 10; i++) begin
      send_word(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0);
      if (i % 3 == 2) wait_drain(1'b1);
    end
    wait_drain(1'b1);
    check_eq("d4_overflow", overflow4, 1'b0);

    // reset while tx_start is high
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) send_word(1'b0, 8'h60 + 8'(i), 1'b1, 1'b0);
    tx_busy = 1'b0;
    wait_start();
    #2 reset = 1'b1;
    #1;
    check_eq("midreset_tx_start", tx_start, 1'b0);
    check_eq("midreset_fifo_count", fifo_count, 5'd0);
    check_eq("midreset_tx_data", tx_data, 8'h00);
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n0 = start_cnt;
    repeat (64) @(negedge clk);
    check_eq("midreset_no_start", start_cnt, n0);
    check_eq("midreset_count_idle", fifo_count, 5'd0);
    send_word(1'b0, 8'h77, 1'b1, 1'b0);
    wait_drain(1'b0);
    check_eq("midreset_new_start", start_cnt, n0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
